// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the MEM-stage branch resolver: branch kinds, FSM states and
// the default wrong-path shadow depth.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    KIND_NONE = 2'd0,
    KIND_BEQ  = 2'd1,
    KIND_BNE  = 2'd2,
    KIND_JUMP = 2'd3
  } brs_kind_e;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_SHADOW = 1'b1
  } brs_state_e;

  // One wrong-path instruction each in IF, ID and EX when the redirect is seen.
  localparam int unsigned DEFAULT_SHADOW = 3;

  // Jump outranks BEQ, which outranks BNE, when decode sets several flags.
  function automatic brs_kind_e decode_kind(input logic is_beq,
                                            input logic is_bne,
                                            input logic is_jump);
    brs_kind_e kind;
    kind = KIND_NONE;
    if (is_jump)     kind = KIND_JUMP;
    else if (is_beq) kind = KIND_BEQ;
    else if (is_bne) kind = KIND_BNE;
    return kind;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// EX-to-MEM branch bus plus the fetch redirect and squash returned to the pipeline.
interface branch_resolve_unit_if;
  // No handshake: EX offers one slot per clock and the resolver samples it on
  // every accepting edge; there is no ready/backpressure in this pipeline.
  logic        ex_valid;
  logic [31:0] ex_pc_4;
  logic [31:0] ex_imm;
  logic [25:0] ex_jump_index;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic        ex_is_beq;
  logic        ex_is_bne;
  logic        ex_is_jump;
  logic        mem_valid;
  logic [31:0] mem_pc_4;
  logic        mem_shouldBranch;
  logic [31:0] mem_branchPc;
  logic        squash;

  modport master (
    output ex_valid, ex_pc_4, ex_imm, ex_jump_index, ex_rs_data, ex_rt_data,
           ex_is_beq, ex_is_bne, ex_is_jump,
    input  mem_valid, mem_pc_4, mem_shouldBranch, mem_branchPc, squash
  );

  modport slave (
    input  ex_valid, ex_pc_4, ex_imm, ex_jump_index, ex_rs_data, ex_rt_data,
           ex_is_beq, ex_is_bne, ex_is_jump,
    output mem_valid, mem_pc_4, mem_shouldBranch, mem_branchPc, squash
  );
endinterface

// File: rtl/branch_cond_eval.sv
// Combinational branch condition and target evaluation for one EX instruction.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  brs_kind_e   kind_i,
  input  logic [31:0] pc_4_i,
  input  logic [31:0] imm_i,
  input  logic [25:0] index_i,
  input  logic [31:0] rs_i,
  input  logic [31:0] rt_i,
  output logic        taken_o,
  output logic [31:0] target_o
);

  logic [31:0] rel_target;
  logic [31:0] abs_target;
  logic        operands_equal;

  // Word offset to byte offset; wraps modulo 2^32.
  assign rel_target     = pc_4_i + (imm_i << 2);
  assign abs_target     = {pc_4_i[31:28], index_i, 2'b00};
  assign operands_equal = (rs_i == rt_i);

  always_comb begin
    taken_o  = 1'b0;
    target_o = rel_target;
    case (kind_i)
      KIND_BEQ:  taken_o = operands_equal;
      KIND_BNE:  taken_o = !operands_equal;
      KIND_JUMP: begin
        taken_o  = 1'b1;
        target_o = abs_target;
      end
      default:   taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// MEM-stage branch resolver: latches EX, issues a one-cycle registered fetch
// redirect, then drops the wrong-path slots behind it. Static not-taken.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned SHADOW      = DEFAULT_SHADOW,
  parameter int unsigned COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  branch_resolve_unit_if.slave   bus,
  output logic [COUNT_WIDTH-1:0] branch_count,
  output logic [COUNT_WIDTH-1:0] taken_count,
  output brs_state_e             dbg_state
);

  localparam int unsigned CNT_W = (SHADOW > 1) ? $clog2(SHADOW) : 1;
  localparam logic [CNT_W-1:0] SHADOW_LAST = CNT_W'(SHADOW - 1);

  brs_state_e             state_q;
  logic [CNT_W-1:0]       shadow_cnt_q;
  logic                   mem_valid_q;
  logic [31:0]            mem_pc_4_q;
  logic                   should_q;
  logic [31:0]            branch_pc_q;
  logic [COUNT_WIDTH-1:0] branch_count_q;
  logic [COUNT_WIDTH-1:0] taken_count_q;

  brs_kind_e   kind;
  logic        taken;
  logic [31:0] target;
  logic        accept;
  logic        is_branch;
  logic        redirect;

  branch_cond_eval u_cond (
    .kind_i   (kind),
    .pc_4_i   (bus.ex_pc_4),
    .imm_i    (bus.ex_imm),
    .index_i  (bus.ex_jump_index),
    .rs_i     (bus.ex_rs_data),
    .rt_i     (bus.ex_rt_data),
    .taken_o  (taken),
    .target_o (target)
  );

  // The last shadow edge already carries the first right-path (target) slot,
  // so it accepts EX while leaving SHADOW; squash still covers that cycle.
  always_comb begin
    kind      = decode_kind(bus.ex_is_beq, bus.ex_is_bne, bus.ex_is_jump);
    accept    = ((state_q == ST_RUN) && !should_q) ||
                ((state_q == ST_SHADOW) && (shadow_cnt_q == '0));
    is_branch = bus.ex_valid && (kind != KIND_NONE);
    redirect  = bus.ex_valid && taken;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= ST_RUN;
      shadow_cnt_q   <= '0;
      mem_valid_q    <= 1'b0;
      mem_pc_4_q     <= '0;
      should_q       <= 1'b0;
      branch_pc_q    <= '0;
      branch_count_q <= '0;
      taken_count_q  <= '0;
    end else begin
      if (state_q == ST_SHADOW) begin
        if (shadow_cnt_q == '0) state_q <= ST_RUN;
        else                    shadow_cnt_q <= shadow_cnt_q - CNT_W'(1);
      end

      if (accept) begin
        mem_valid_q <= bus.ex_valid;
        mem_pc_4_q  <= bus.ex_pc_4;
        should_q    <= redirect;
        if (redirect) begin
          branch_pc_q <= target;
          if (taken_count_q != '1) taken_count_q <= taken_count_q + COUNT_WIDTH'(1);
        end
        if (is_branch && (branch_count_q != '1))
          branch_count_q <= branch_count_q + COUNT_WIDTH'(1);
      end else if (should_q) begin
        state_q      <= ST_SHADOW;
        shadow_cnt_q <= SHADOW_LAST;
        mem_valid_q  <= 1'b0;
        should_q     <= 1'b0;
      end else begin
        mem_valid_q <= 1'b0;
        should_q    <= 1'b0;
      end
    end
  end

  assign bus.mem_valid        = mem_valid_q;
  assign bus.mem_pc_4         = mem_pc_4_q;
  assign bus.mem_shouldBranch = should_q;
  assign bus.mem_branchPc     = branch_pc_q;
  assign bus.squash           = should_q | (state_q == ST_SHADOW);
  assign branch_count         = branch_count_q;
  assign taken_count          = taken_count_q;
  assign dbg_state            = state_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: a 16-bit-counter instance checked
// cycle by cycle and a 2-bit-counter instance for saturation, sharing stimulus.
module tb_branch_resolve_unit;
  import branch_resolve_unit_pkg::*;

  localparam int W = 67;  // {valid, pc_4, shouldBranch, branchPc, squash}

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  branch_resolve_unit_if bus ();
  branch_resolve_unit_if bus_s ();

  assign bus_s.ex_valid      = bus.ex_valid;
  assign bus_s.ex_pc_4       = bus.ex_pc_4;
  assign bus_s.ex_imm        = bus.ex_imm;
  assign bus_s.ex_jump_index = bus.ex_jump_index;
  assign bus_s.ex_rs_data    = bus.ex_rs_data;
  assign bus_s.ex_rt_data    = bus.ex_rt_data;
  assign bus_s.ex_is_beq     = bus.ex_is_beq;
  assign bus_s.ex_is_bne     = bus.ex_is_bne;
  assign bus_s.ex_is_jump    = bus.ex_is_jump;

  logic [15:0] bc, tc;
  logic [1:0]  bc_s, tc_s;
  brs_state_e  st, st_s;

  branch_resolve_unit #(.SHADOW(3), .COUNT_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .branch_count(bc), .taken_count(tc), .dbg_state(st)
  );

  branch_resolve_unit #(.SHADOW(3), .COUNT_WIDTH(2)) dut_sat (
    .clock(clock), .reset(reset), .bus(bus_s),
    .branch_count(bc_s), .taken_count(tc_s), .dbg_state(st_s)
  );

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int exp_bc = 0;
  int exp_tc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat3(input int x);
    return (x > 3) ? 32'd3 : 32'(x);
  endfunction

  task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [25:0] idx, input logic [31:0] rs, input logic [31:0] rt,
                       input logic beq, input logic bne, input logic j);
    bus.ex_valid      = v;
    bus.ex_pc_4       = pc4;
    bus.ex_imm        = imm;
    bus.ex_jump_index = idx;
    bus.ex_rs_data    = rs;
    bus.ex_rt_data    = rt;
    bus.ex_is_beq     = beq;
    bus.ex_is_bne     = bne;
    bus.ex_is_jump    = j;
  endtask

  task automatic drive_idle();
    drive(1'b0, 32'h0, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_push(input logic v, input logic [31:0] pc, input logic sb,
                          input logic [31:0] bpc, input logic sq);
    exp_q.push_back({v, pc, sb, bpc, sq});
  endtask

  task automatic pop_check(input string tag);
    logic [W-1:0] e;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_err++;
      $error("FAIL %s.queue: observed empty scoreboard expected an entry", tag);
    end
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, ".valid"}, 32'(bus.mem_valid), 32'(e[66]));
      if (e[66]) chk({tag, ".pc_4"}, bus.mem_pc_4, e[65:34]);
      chk({tag, ".should"}, 32'(bus.mem_shouldBranch), 32'(e[33]));
      chk({tag, ".bpc"}, bus.mem_branchPc, e[32:1]);
      chk({tag, ".squash"}, 32'(bus.squash), 32'(e[0]));
    end
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    #1;
    pop_check(tag);
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, ".bc"}, 32'(bc), 32'(exp_bc));
    chk({tag, ".tc"}, 32'(tc), 32'(exp_tc));
    chk({tag, ".bc_sat"}, 32'(bc_s), sat3(exp_bc));
    chk({tag, ".tc_sat"}, 32'(tc_s), sat3(exp_tc));
  endtask

  // Three dropped slots after a redirect; inject=1 feeds taken BEQs.
  task automatic shadow_tail(input string tag, input logic [31:0] bpc, input logic inject);
    for (int i = 0; i < 3; i++) begin
      if (inject) drive(1'b1, 32'h300 + 32'(i * 4), 32'h40, 26'h0, 32'h9, 32'h9, 1'b1, 1'b0, 1'b0);
      else        drive(1'b1, 32'h400 + 32'(i * 4), 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      exp_push(1'b0, 32'h0, 1'b0, bpc, 1'b1);
      step({tag, ".shadow"});
      chk({tag, ".state"}, 32'(st), 32'(ST_SHADOW));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected end of test");
    $fatal(1);
  end

  initial begin
    logic [31:0] tgt;
    reset = 1'b1;
    drive_idle();
    exp_push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("reset");
    chk_counts("reset");
    chk("reset.state", 32'(st), 32'(ST_RUN));
    #2 reset = 1'b0;

    // BEQ not taken
    drive(1'b1, 32'h10, 32'h4, 26'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    exp_push(1'b1, 32'h10, 1'b0, 32'h0, 1'b0);
    step("beq_nt");
    exp_bc = 1;
    chk_counts("beq_nt");

    // BEQ taken, then shadow and target acceptance
    drive(1'b1, 32'h10, 32'h4, 26'h0, 32'h7, 32'h7, 1'b1, 1'b0, 1'b0);
    exp_push(1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
    step("beq_t");
    exp_bc = 2; exp_tc = 1;
    chk_counts("beq_t");
    shadow_tail("beq_t", 32'h20, 1'b0);
    drive(1'b1, 32'h24, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_push(1'b1, 32'h24, 1'b0, 32'h20, 1'b0);
    step("beq_t.target");
    chk("beq_t.run", 32'(st), 32'(ST_RUN));
    chk_counts("beq_t.after");

    // BNE with negative offset
    drive(1'b1, 32'h100, 32'hFFFF_FFFE, 26'h0, 32'h1, 32'h2, 1'b0, 1'b1, 1'b0);
    exp_push(1'b1, 32'h100, 1'b1, 32'hF8, 1'b1);
    step("bne_neg");
    exp_bc = 3; exp_tc = 2;
    shadow_tail("bne_neg", 32'hF8, 1'b0);
    drive_idle();
    exp_push(1'b0, 32'h0, 1'b0, 32'hF8, 1'b0);
    step("bne_neg.end");
    chk_counts("bne_neg");

    // BEQ outranks BNE
    drive(1'b1, 32'h40, 32'h1, 26'h0, 32'h5, 32'h5, 1'b1, 1'b1, 1'b0);
    exp_push(1'b1, 32'h40, 1'b1, 32'h44, 1'b1);
    step("prio_beq");
    exp_bc = 4; exp_tc = 3;
    shadow_tail("prio_beq", 32'h44, 1'b1);
    drive_idle();
    exp_push(1'b0, 32'h0, 1'b0, 32'h44, 1'b0);
    step("prio_beq.end");
    chk_counts("prio_beq");

    // Jump outranks a not-taken BEQ
    drive(1'b1, 32'h3000_0004, 32'h100, 26'h10, 32'h1, 32'h2, 1'b1, 1'b0, 1'b1);
    exp_push(1'b1, 32'h3000_0004, 1'b1, 32'h3000_0040, 1'b1);
    step("jump");
    exp_bc = 5; exp_tc = 4;
    shadow_tail("jump", 32'h3000_0040, 1'b0);
    drive_idle();
    exp_push(1'b0, 32'h0, 1'b0, 32'h3000_0040, 1'b0);
    step("jump.end");
    chk_counts("jump");

    // Invalid slot carrying a taken BEQ: ignored
    drive(1'b0, 32'h60, 32'h4, 26'h0, 32'h3, 32'h3, 1'b1, 1'b0, 1'b0);
    exp_push(1'b0, 32'h0, 1'b0, 32'h3000_0040, 1'b0);
    step("invalid");
    chk_counts("invalid");

    // Taken BEQs in the shadow are dropped; 4th slot accepted
    drive(1'b1, 32'h200, 32'h8, 26'h0, 32'h4, 32'h4, 1'b1, 1'b0, 1'b0);
    exp_push(1'b1, 32'h200, 1'b1, 32'h220, 1'b1);
    step("shadow_drop");
    exp_bc = 6; exp_tc = 5;
    shadow_tail("shadow_drop", 32'h220, 1'b1);
    drive(1'b1, 32'h224, 32'h8, 26'h0, 32'h1, 32'h2, 1'b1, 1'b0, 1'b0);
    exp_push(1'b1, 32'h224, 1'b0, 32'h220, 1'b0);
    step("shadow_drop.fourth");
    exp_bc = 7;
    drive_idle();
    exp_push(1'b0, 32'h0, 1'b0, 32'h220, 1'b0);
    step("shadow_drop.idle");
    chk_counts("shadow_drop");

    // Reset during a pending redirect
    drive(1'b1, 32'h500, 32'h4, 26'h0, 32'h2, 32'h2, 1'b1, 1'b0, 1'b0);
    exp_push(1'b1, 32'h500, 1'b1, 32'h510, 1'b1);
    step("rst_mid.branch");
    reset = 1'b1;
    #1;
    exp_push(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    pop_check("rst_mid");
    exp_bc = 0; exp_tc = 0;
    chk_counts("rst_mid");
    chk("rst_mid.state", 32'(st), 32'(ST_RUN));
    #1 reset = 1'b0;
    drive(1'b1, 32'h50, 32'h0, 26'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    exp_push(1'b1, 32'h50, 1'b0, 32'h0, 1'b0);
    step("rst_mid.resume");

    // Five spaced taken jumps: 2-bit counters stop at 3
    for (int k = 0; k < 5; k++) begin
      tgt = 32'h1000_0000 | (32'(k + 1) << 2);
      drive(1'b1, 32'h1000_0000 + 32'(k * 32'h100), 32'h0, 26'(k + 1),
            32'h0, 32'h1, 1'b0, 1'b0, 1'b1);
      exp_push(1'b1, 32'h1000_0000 + 32'(k * 32'h100), 1'b1, tgt, 1'b1);
      step("sat.jump");
      exp_bc++; exp_tc++;
      shadow_tail("sat", tgt, 1'b0);
      drive_idle();
      exp_push(1'b0, 32'h0, 1'b0, tgt, 1'b0);
      step("sat.end");
      chk_counts("sat");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
